// File: rtl/score_submitter.sv
// Score-tracker request initiator: queues finished-game results in a small FIFO,
// submits them one at a time and returns each verdict (or a timeout) as a strobe.
module score_submitter #(
  parameter int DEPTH     = 4,
  parameter int TIMEOUT   = 16,
  parameter int MAX_SCORE = 99
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       game_done,
  input  logic [6:0]                 game_score,
  input  logic [2:0]                 game_playerID,
  input  logic                       game_isGuest,
  output logic                       score_req,
  output logic [6:0]                 score,
  output logic [2:0]                 playerID,
  output logic                       isGuest,
  input  logic                       valid,
  input  logic                       personal_winner,
  input  logic                       global_winner,
  output logic                       result_valid,
  output logic                       result_personal,
  output logic                       result_global,
  output logic [2:0]                 result_playerID,
  output logic                       reject,
  output logic                       timeout_err,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT);
  localparam int EW = 11;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] T_ONE  = CW'(1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state;
  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr, rd_nxt;
  logic [AW:0]     count, cnt_nxt, remain;
  logic [CW-1:0]   tcnt;
  logic [EW-1:0]   new_entry, head_nxt;
  logic            pop, push, got_valid, expire;

  function automatic logic score_ok(input logic [6:0] s);
    return int'(s) <= MAX_SCORE;
  endfunction

  assign pending   = count;
  assign new_entry = {game_score, game_playerID, game_isGuest};

  always_comb begin
    got_valid = (state == WAIT) && valid;
    expire    = (state == WAIT) && !valid && (tcnt == T_LAST);
    pop       = got_valid || expire;
    push      = game_done && score_ok(game_score) && ((count < CNT_FULL) || pop);
    rd_nxt    = pop ? rd_ptr + PTR_ONE : rd_ptr;
    remain    = pop ? count - CNT_ONE : count;
    cnt_nxt   = push ? remain + CNT_ONE : remain;
    // An entry pushed into an (effectively) empty FIFO becomes the head directly
    if (remain != '0)
      head_nxt = mem[rd_nxt];
    else if (push)
      head_nxt = new_entry;
    else
      head_nxt = '0;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      count           <= '0;
      tcnt            <= '0;
      score_req       <= 1'b0;
      score           <= '0;
      playerID        <= '0;
      isGuest         <= 1'b0;
      result_valid    <= 1'b0;
      result_personal <= 1'b0;
      result_global   <= 1'b0;
      result_playerID <= '0;
      reject          <= 1'b0;
      timeout_err     <= 1'b0;
    end else begin
      score_req    <= 1'b0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      reject       <= game_done && !push;
      rd_ptr       <= rd_nxt;
      count        <= cnt_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      {score, playerID, isGuest} <= head_nxt;
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= REQ;
            score_req <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT;
          tcnt  <= '0;
        end
        WAIT: begin
          tcnt <= tcnt + T_ONE;
          if (got_valid) begin
            result_valid    <= 1'b1;
            result_personal <= personal_winner;
            result_global   <= global_winner;
            result_playerID <= playerID;
            state           <= IDLE;
          end else if (expire) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_submitter.sv
// Scoreboard bench for score_submitter: expected requests and verdicts are queued
// as stimulus is driven and compared when the DUT strobes score_req / result_valid.
module tb_score_submitter;
  localparam int DEPTH = 4, TIMEOUT = 16, MAX_SCORE = 99;

  logic clk = 1'b0, rst = 1'b1;
  logic game_done = 0, game_isGuest = 0, valid = 0, personal_winner = 0, global_winner = 0;
  logic [6:0] game_score = '0;
  logic [2:0] game_playerID = '0;
  logic score_req, isGuest, result_valid, result_personal, result_global, reject, timeout_err;
  logic [6:0] score;
  logic [2:0] playerID, result_playerID;
  logic [2:0] pending;

  typedef struct packed {logic [6:0] s; logic [2:0] id; logic g;} req_t;
  typedef struct packed {logic p; logic gl; logic [2:0] id;} res_t;

  req_t exp_req[$];
  res_t exp_res[$];
  req_t inflight;
  int n_cmp = 0, n_bad = 0;
  int n_req = 0, n_res = 0, n_rej = 0, n_to = 0;
  int cyc = 0, req_cyc = 0, to_cyc = 0;

  score_submitter #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .MAX_SCORE(MAX_SCORE)) dut (
    .clk(clk), .rst(rst), .game_done(game_done), .game_score(game_score),
    .game_playerID(game_playerID), .game_isGuest(game_isGuest),
    .score_req(score_req), .score(score), .playerID(playerID), .isGuest(isGuest),
    .valid(valid), .personal_winner(personal_winner), .global_winner(global_winner),
    .result_valid(result_valid), .result_personal(result_personal),
    .result_global(result_global), .result_playerID(result_playerID),
    .reject(reject), .timeout_err(timeout_err), .pending(pending)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_loop();
    req_t e;
    res_t r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (score_req) begin
          n_req++;
          req_cyc = cyc;
          if (exp_req.size() == 0) check("req_unexpected", 32'(1), 32'(0));
          else begin
            e = exp_req.pop_front();
            inflight = e;
            check("req_score", 32'(score), 32'(e.s));
            check("req_id", 32'(playerID), 32'(e.id));
            check("req_guest", 32'(isGuest), 32'(e.g));
          end
        end
        if (result_valid) begin
          n_res++;
          if (exp_res.size() == 0) check("res_unexpected", 32'(1), 32'(0));
          else begin
            r = exp_res.pop_front();
            check("res_personal", 32'(result_personal), 32'(r.p));
            check("res_global", 32'(result_global), 32'(r.gl));
            check("res_id", 32'(result_playerID), 32'(r.id));
          end
        end
        if (reject) n_rej++;
        if (timeout_err) begin
          n_to++;
          to_cyc = cyc;
        end
      end
    end
  endtask

  task automatic submit(input logic [6:0] s, input logic [2:0] id, input logic g, input bit acc);
    req_t e;
    game_done = 1; game_score = s; game_playerID = id; game_isGuest = g;
    if (acc) begin
      e.s = s; e.id = id; e.g = g;
      exp_req.push_back(e);
    end
    tick();
    game_done = 0;
  endtask

  task automatic answer(input logic p, input logic gl, input bit dp,
                        input logic [6:0] s, input logic [2:0] id, input logic g);
    res_t r;
    req_t e;
    valid = 1; personal_winner = p; global_winner = gl;
    r.p = p; r.gl = gl; r.id = inflight.id;
    exp_res.push_back(r);
    if (dp) begin
      game_done = 1; game_score = s; game_playerID = id; game_isGuest = g;
      e.s = s; e.id = id; e.g = g;
      exp_req.push_back(e);
    end
    tick();
    valid = 0; personal_winner = 0; global_winner = 0; game_done = 0;
  endtask

  task automatic wait_req();
    int b = n_req;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (n_req > b) return;
    end
    check("req_wait_expired", 32'(0), 32'(1));
  endtask

  task automatic wait_to();
    int b = n_to;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (n_to > b) return;
    end
    check("timeout_wait_expired", 32'(0), 32'(1));
  endtask

  task automatic check_zero(input string pre);
    check({pre, "_score_req"}, 32'(score_req), 32'(0));
    check({pre, "_score"}, 32'(score), 32'(0));
    check({pre, "_playerID"}, 32'(playerID), 32'(0));
    check({pre, "_isGuest"}, 32'(isGuest), 32'(0));
    check({pre, "_result_valid"}, 32'(result_valid), 32'(0));
    check({pre, "_result_personal"}, 32'(result_personal), 32'(0));
    check({pre, "_result_global"}, 32'(result_global), 32'(0));
    check({pre, "_result_playerID"}, 32'(result_playerID), 32'(0));
    check({pre, "_reject"}, 32'(reject), 32'(0));
    check({pre, "_timeout_err"}, 32'(timeout_err), 32'(0));
    check({pre, "_pending"}, 32'(pending), 32'(0));
  endtask

  initial begin
    int b_rej, b_req, b_res, first_req;
    fork
      mon_loop();
    join_none

    // reset state
    repeat (3) tick();
    check_zero("reset");
    rst = 0;
    tick();

    // single submit, answered two cycles after score_req
    submit(7'd42, 3'd3, 1'b0, 1);
    check("single_pending_t1", 32'(pending), 32'(1));
    check("single_req_t1", 32'(score_req), 32'(0));
    tick();
    check("single_req_t2", 32'(score_req), 32'(1));
    tick();
    check("single_req_drop", 32'(score_req), 32'(0));
    check("single_hold_score", 32'(score), 32'(42));
    check("single_hold_id", 32'(playerID), 32'(3));
    tick();
    check("single_hold_score2", 32'(score), 32'(42));
    answer(1'b1, 1'b0, 0, '0, '0, 1'b0);
    check("single_result_valid", 32'(result_valid), 32'(1));
    check("single_pending_end", 32'(pending), 32'(0));
    tick();
    check("single_result_drop", 32'(result_valid), 32'(0));
    check("single_result_hold_p", 32'(result_personal), 32'(1));
    check("single_result_hold_id", 32'(result_playerID), 32'(3));

    // range check
    b_rej = n_rej; b_req = n_req;
    submit(7'd100, 3'd2, 1'b0, 0);
    check("range_pending", 32'(pending), 32'(0));
    tick();
    check("range_reject", 32'(n_rej), 32'(b_rej + 1));
    repeat (4) tick();
    check("range_no_req", 32'(n_req), 32'(b_req));
    submit(7'd99, 3'd5, 1'b1, 1);
    wait_req();
    answer(1'b0, 1'b1, 0, '0, '0, 1'b0);
    tick();

    // fill / overflow / timeout
    b_rej = n_rej;
    for (int i = 0; i < 5; i++)
      submit(7'(10 + i), 3'(i), 1'(i % 2), i < 4);
    check("fill_pending", 32'(pending), 32'(4));
    tick();
    check("fill_reject", 32'(n_rej), 32'(b_rej + 1));
    first_req = req_cyc;
    wait_to();
    check("timeout_latency", 32'(to_cyc - first_req), 32'(TIMEOUT + 1));
    check("timeout_pending", 32'(pending), 32'(3));
    for (int i = 0; i < 3; i++) begin
      wait_req();
      answer(1'(i % 2), 1'b1, 0, '0, '0, 1'b0);
    end
    tick();

    // push on the cycle a full FIFO pops
    b_rej = n_rej;
    for (int i = 0; i < 4; i++)
      submit(7'(60 + i), 3'(7 - i), 1'b0, 1);
    check("full_pending", 32'(pending), 32'(4));
    answer(1'b1, 1'b1, 1, 7'd77, 3'd7, 1'b1);
    check("pushpop_pending", 32'(pending), 32'(4));
    tick();
    check("pushpop_no_reject", 32'(n_rej), 32'(b_rej));
    for (int i = 0; i < 4; i++) begin
      wait_req();
      answer(1'((i + 1) % 2), 1'(i % 2), 0, '0, '0, 1'b0);
    end
    tick();

    // FIFO wrap: ten entries, IDs 0..7,0,1
    b_res = n_res;
    for (int k = 0; k < 5; k++) begin
      submit(7'(20 + 2 * k), 3'((2 * k) % 8), 1'b0, 1);
      submit(7'(21 + 2 * k), 3'((2 * k + 1) % 8), 1'b1, 1);
      wait_req();
      answer(1'(k % 2), 1'b0, 0, '0, '0, 1'b0);
      wait_req();
      answer(1'b0, 1'(k % 2), 0, '0, '0, 1'b0);
    end
    tick();
    check("wrap_results", 32'(n_res - b_res), 32'(10));

    // reset while waiting for the tracker
    submit(7'd50, 3'd6, 1'b1, 1);
    wait_req();
    tick();
    rst = 1;
    tick();
    tick();
    check_zero("rst_mid");
    rst = 0;
    b_res = n_res; b_req = n_req;
    valid = 1; personal_winner = 1; global_winner = 1;
    tick();
    valid = 0; personal_winner = 0; global_winner = 0;
    repeat (3) tick();
    check("rst_no_result", 32'(n_res), 32'(b_res));
    check("rst_no_req", 32'(n_req), 32'(b_req));
    check_zero("post_rst");

    check("exp_req_drained", 32'(exp_req.size()), 32'(0));
    check("exp_res_drained", 32'(exp_res.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/score_submitter.md
# score_submitter

Initiator side of the score-tracking request interface. Buffers finished-game results from the game logic in a small FIFO and submits them one at a time to the score tracker (`score_req`/`score`/`playerID`/`isGuest` out, `valid`/`personal_winner`/`global_winner` back). It returns each tracker verdict to the game/display logic as a one-cycle result strobe, with a timeout guard against a non-responding tracker.

## Interface
- `DEPTH`, 4: FIFO entries (power of two, ≥2).
- `TIMEOUT`, 16: cycles in WAIT without `valid` before the entry is abandoned (≥2).
- `MAX_SCORE`, 99: largest acceptable score; larger values are rejected at entry.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `game_done`  in  1  one-cycle strobe: a game finished, fields below valid this cycle.
- `game_score`  in  7  final score.
- `game_playerID`  in  3  player slot.
- `game_isGuest`  in  1  guest flag.
- `score_req`  out  1  request strobe to tracker.
- `score`  out  7  score to tracker.
- `playerID`  out  3  player slot to tracker.
- `isGuest`  out  1  guest flag to tracker.
- `valid`  in  1  tracker response strobe.
- `personal_winner`  in  1  tracker verdict, qualified by `valid`.
- `global_winner`  in  1  tracker verdict, qualified by `valid`.
- `result_valid`  out  1  one-cycle strobe: verdict available.
- `result_personal`  out  1  latched `personal_winner`.
- `result_global`  out  1  latched `global_winner`.
- `result_playerID`  out  3  player the verdict belongs to.
- `reject`  out  1  one-cycle strobe: entry dropped (FIFO full or score > MAX_SCORE).
- `timeout_err`  out  1  one-cycle strobe: tracker did not answer.
- `pending`  out  log2(DEPTH)+1  FIFO occupancy.

## Operation
- Entry: on `game_done`, entry {score, playerID, isGuest} is written if `game_score` ≤ MAX_SCORE and (occupancy < DEPTH, or a pop occurs the same cycle). Otherwise it is discarded and `reject` pulses the following cycle.
- FSM states IDLE, REQ, WAIT.
  - IDLE: when FIFO non-empty, go to REQ.
  - REQ (exactly 1 cycle): `score_req`=1; drive head entry on `score`/`playerID`/`isGuest`; go to WAIT; clear timeout counter.
  - WAIT: hold head fields stable and keep `score_req`=0; the counter increments each cycle.
    - If `valid`=1: latch `personal_winner`, `global_winner` and the head `playerID`; pop the head; go to IDLE.
    - Else if the counter reaches TIMEOUT−1: pop the head, pulse `timeout_err` next cycle, go to IDLE.
- Outside WAIT, `valid` is ignored; no latch and no pop.
- In IDLE and WAIT, `score`/`playerID`/`isGuest` show the FIFO head (0 when empty). They are stable from REQ through WAIT.
- FIFO: circular read/write pointers with wrap-around; occupancy counter. Simultaneous push and pop leaves `pending` unchanged.
- Reset: FIFO emptied, state IDLE, counter 0. An in-flight transaction is abandoned with no result or timeout strobe.
  - All outputs 0 after reset: `score_req`, `score`, `playerID`, `isGuest`, `result_*`, `reject`, `timeout_err`, `pending`.

## Timing
- All outputs are registered.
- `game_done` at cycle t into an empty FIFO with the FSM in IDLE:
  - `pending`=1 at t+1;
  - FSM enters REQ at t+2, so `score_req`=1 during cycle t+2;
  - earliest WAIT cycle is t+3.
- `valid` sampled at WAIT cycle w: `result_valid`=1 for exactly cycle w+1, with `result_personal`/`result_global`/`result_playerID`. Those three hold their value until the next result; `result_valid` drops after one cycle.
- Back-to-back entries: minimum 3 cycles per transaction (REQ, WAIT, IDLE); next `score_req` no earlier than w+2.
- Timeout: with REQ at cycle r and no `valid`, WAIT spans r+1..r+TIMEOUT; `timeout_err`=1 at r+TIMEOUT+1.
- `valid` on the last WAIT cycle wins over timeout.
- `reject` and `timeout_err` can be high in the same cycle.

## Test plan
- Single submit: game_done(score=42, ID=3, guest=0); tracker returns valid=1, personal=1, global=0 two cycles after `score_req` -> one `score_req` pulse with 42/3/0 held through WAIT; result_valid one cycle later with personal=1, global=0, ID=3; pending 1→0.
- Fill/overflow: 5 game_done strobes, tracker silent, DEPTH=4 -> pending=4; 5th gives reject=1. First entry times out at REQ+TIMEOUT+1, timeout_err=1, pending=3.
- Push on the cycle `valid` pops a full FIFO -> accepted, no reject, pending stays 4.
- Range check: game_score=100 -> reject=1; pending unchanged; no score_req. game_score=99 -> accepted.
- FIFO wrap: 10 entries (IDs 0..7,0,1) each answered after one WAIT cycle -> `score_req` order and `result_playerID` order match input order across pointer wrap.
- Reset mid-WAIT: assert rst while awaiting valid, then valid pulses after rst drops -> no result_valid; all outputs 0; pending=0; state IDLE.
